// File: rtl/saes_round_controller.sv
// Simplified-AES round sequencer: whitening plus NUM_ROUNDS rounds over a DATA_W-bit state.
// Optional macro SAES_DECRYPT_EN adds a `decrypt` input that walks the key schedule in reverse.

module saes_add_round_key #(
    parameter int unsigned DATA_W = 64
) (
    input  logic [DATA_W-1:0] state_in,
    input  logic [DATA_W-1:0] round_key,
    output logic [DATA_W-1:0] state_out
);
    assign state_out = state_in ^ round_key;
endmodule

module saes_round_controller #(
    parameter  int unsigned DATA_W     = 64,
    parameter  int unsigned NUM_ROUNDS = 2,
    localparam int unsigned IDX_W      = $clog2(NUM_ROUNDS + 1)
) (
    input  logic              clk,
    input  logic              rst,
`ifdef SAES_DECRYPT_EN
    input  logic              decrypt,
`endif
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] plainText,
    output logic [IDX_W-1:0]  keyIdx,
    input  logic [DATA_W-1:0] roundKey,
    output logic [DATA_W-1:0] roundFuncIn,
    input  logic [DATA_W-1:0] roundFuncOut,
    output logic              lastRound,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] cipherText
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } fsm_t;

    localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(NUM_ROUNDS);
    localparam logic [IDX_W-1:0] ONE_CNT  = IDX_W'(1);

    fsm_t              fsm_q, fsm_d;
    logic [DATA_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]  round_cnt_q, round_cnt_d;
    logic [IDX_W-1:0]  key_idx_q, key_idx_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              last_round_q, last_round_d;
    logic              dec_q, dec_d;

    logic              dec_start;
    logic [IDX_W-1:0]  cnt_inc;
    logic [DATA_W-1:0] ark_in;
    logic [DATA_W-1:0] ark_out;

`ifdef SAES_DECRYPT_EN
    assign dec_start = decrypt;
`else
    assign dec_start = 1'b0;
`endif

    function automatic logic [IDX_W-1:0] idx_for(input logic [IDX_W-1:0] cnt, input logic dec);
        return dec ? (LAST_CNT - cnt) : cnt;
    endfunction

    // Decrypt runs the inverse datapath, whose MixColumns skip lands on the first round.
    function automatic logic last_for(input logic [IDX_W-1:0] cnt, input logic dec);
        return dec ? (cnt == ONE_CNT) : (cnt == LAST_CNT);
    endfunction

    assign cnt_inc = round_cnt_q + ONE_CNT;
    assign ark_in  = (fsm_q == S_IDLE) ? plainText : roundFuncOut;

    saes_add_round_key #(
        .DATA_W(DATA_W)
    ) u_ark (
        .state_in (ark_in),
        .round_key(roundKey),
        .state_out(ark_out)
    );

    always_comb begin
        fsm_d        = fsm_q;
        state_d      = state_q;
        round_cnt_d  = round_cnt_q;
        key_idx_d    = key_idx_q;
        in_ready_d   = in_ready_q;
        out_valid_d  = out_valid_q;
        last_round_d = last_round_q;
        dec_d        = dec_q;

        case (fsm_q)
            S_IDLE: begin
                if (inValid) begin
                    state_d      = ark_out;
                    round_cnt_d  = ONE_CNT;
                    dec_d        = dec_start;
                    key_idx_d    = idx_for(ONE_CNT, dec_start);
                    last_round_d = last_for(ONE_CNT, dec_start);
                    in_ready_d   = 1'b0;
                    fsm_d        = S_ROUND;
                end
            end
            S_ROUND: begin
                state_d = ark_out;
                if (round_cnt_q == LAST_CNT) begin
                    fsm_d        = S_DONE;
                    out_valid_d  = 1'b1;
                    key_idx_d    = '0;
                    last_round_d = 1'b0;
                end else begin
                    round_cnt_d  = cnt_inc;
                    key_idx_d    = idx_for(cnt_inc, dec_q);
                    last_round_d = last_for(cnt_inc, dec_q);
                end
            end
            S_DONE: begin
                if (outReady) begin
                    fsm_d       = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    round_cnt_d = '0;
                    dec_d       = 1'b0;
                end
            end
            default: begin
                fsm_d        = S_IDLE;
                round_cnt_d  = '0;
                key_idx_d    = '0;
                in_ready_d   = 1'b1;
                out_valid_d  = 1'b0;
                last_round_d = 1'b0;
                dec_d        = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q        <= S_IDLE;
            state_q      <= '0;
            round_cnt_q  <= '0;
            key_idx_q    <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            last_round_q <= 1'b0;
            dec_q        <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            state_q      <= state_d;
            round_cnt_q  <= round_cnt_d;
            key_idx_q    <= key_idx_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            last_round_q <= last_round_d;
            dec_q        <= dec_d;
        end
    end

    // The whitening key must be addressed in the same cycle the block is offered.
`ifdef SAES_DECRYPT_EN
    assign keyIdx = (fsm_q == S_IDLE && decrypt) ? LAST_CNT : key_idx_q;
`else
    assign keyIdx = key_idx_q;
`endif

    assign inReady     = in_ready_q;
    assign outValid    = out_valid_q;
    assign lastRound   = last_round_q;
    assign roundFuncIn = state_q;
    assign cipherText  = state_q;

endmodule
